dma_client_axis_sink: RTL

Receives an AXI stream frame and writes it into the segmented DMA client RAM starting at a descriptor-supplied address, then reports completion on a status channel. Sits between a stream producer (e.g. MAC RX path) and the segmented RAM write port of the DMA interface. It is the write-direction counterpart to the existing stream-source DMA client.

---
 rtl/dma_client_axis_sink_pkg.sv | 32 +++
 rtl/dma_client_axis_sink_if.sv | 83 ++++++++
 rtl/dma_client_axis_sink_seg.sv | 65 ++++++
 rtl/dma_client_axis_sink.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dma_client_axis_sink_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dma_client_axis_sink_pkg
//  Brief    : Shared types and helpers for the AXI stream to segmented RAM sink.
//  Revision : 1.0 - initial release
// ============================================================================
package dma_client_axis_sink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int unsigned c_max_keep_width = 256;

    function automatic int unsigned popcount(input logic [c_max_keep_width-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < c_max_keep_width; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    // Byte address to segment word address shift for a given stream width.
    function automatic int unsigned seg_addr_shift(input int unsigned keep_width);
        return $clog2(keep_width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_client_axis_sink_if.sv
`default_nettype none
// ============================================================================
//  Module   : dma_client_axis_sink_if
//  Brief    : Descriptor, status, stream and segmented RAM write bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface dma_client_axis_sink_if #(
    parameter int SEG_COUNT       = 2,
    parameter int SEG_DATA_WIDTH  = 64,
    parameter int SEG_ADDR_WIDTH  = 8,
    parameter int SEG_BE_WIDTH    = SEG_DATA_WIDTH/8,
    parameter int RAM_ADDR_WIDTH  = SEG_ADDR_WIDTH+$clog2(SEG_COUNT)+$clog2(SEG_BE_WIDTH),
    parameter int AXIS_DATA_WIDTH = SEG_COUNT*SEG_DATA_WIDTH,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
    parameter int AXIS_ID_WIDTH   = 8,
    parameter int AXIS_DEST_WIDTH = 8,
    parameter int AXIS_USER_WIDTH = 1,
    parameter int LEN_WIDTH       = 20,
    parameter int TAG_WIDTH       = 8
) ();
    logic [RAM_ADDR_WIDTH-1:0]           s_axis_write_desc_ram_addr;
    logic [LEN_WIDTH-1:0]                s_axis_write_desc_len;
    logic [TAG_WIDTH-1:0]                s_axis_write_desc_tag;
    logic                                s_axis_write_desc_valid;
    logic                                s_axis_write_desc_ready;

    logic [LEN_WIDTH-1:0]                m_axis_write_desc_status_len;
    logic [TAG_WIDTH-1:0]                m_axis_write_desc_status_tag;
    logic [AXIS_ID_WIDTH-1:0]            m_axis_write_desc_status_id;
    logic [AXIS_DEST_WIDTH-1:0]          m_axis_write_desc_status_dest;
    logic [AXIS_USER_WIDTH-1:0]          m_axis_write_desc_status_user;
    logic                                m_axis_write_desc_status_error;
    logic                                m_axis_write_desc_status_valid;

    logic [AXIS_DATA_WIDTH-1:0]          s_axis_write_data_tdata;
    logic [AXIS_KEEP_WIDTH-1:0]          s_axis_write_data_tkeep;
    logic                                s_axis_write_data_tvalid;
    logic                                s_axis_write_data_tready;
    logic                                s_axis_write_data_tlast;
    logic [AXIS_ID_WIDTH-1:0]            s_axis_write_data_tid;
    logic [AXIS_DEST_WIDTH-1:0]          s_axis_write_data_tdest;
    logic [AXIS_USER_WIDTH-1:0]          s_axis_write_data_tuser;

    logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   ram_wr_cmd_be;
    logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] ram_wr_cmd_addr;
    logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] ram_wr_cmd_data;
    logic [SEG_COUNT-1:0]                ram_wr_cmd_valid;
    logic [SEG_COUNT-1:0]                ram_wr_cmd_ready;
    logic [SEG_COUNT-1:0]                ram_wr_done;

    modport slave (
        input  s_axis_write_desc_ram_addr, s_axis_write_desc_len, s_axis_write_desc_tag,
               s_axis_write_desc_valid,
        output s_axis_write_desc_ready,
        output m_axis_write_desc_status_len, m_axis_write_desc_status_tag,
               m_axis_write_desc_status_id, m_axis_write_desc_status_dest,
               m_axis_write_desc_status_user, m_axis_write_desc_status_error,
               m_axis_write_desc_status_valid,
        input  s_axis_write_data_tdata, s_axis_write_data_tkeep, s_axis_write_data_tvalid,
               s_axis_write_data_tlast, s_axis_write_data_tid, s_axis_write_data_tdest,
               s_axis_write_data_tuser,
        output s_axis_write_data_tready,
        output ram_wr_cmd_be, ram_wr_cmd_addr, ram_wr_cmd_data, ram_wr_cmd_valid,
        input  ram_wr_cmd_ready, ram_wr_done
    );

    modport master (
        output s_axis_write_desc_ram_addr, s_axis_write_desc_len, s_axis_write_desc_tag,
               s_axis_write_desc_valid,
        input  s_axis_write_desc_ready,
        input  m_axis_write_desc_status_len, m_axis_write_desc_status_tag,
               m_axis_write_desc_status_id, m_axis_write_desc_status_dest,
               m_axis_write_desc_status_user, m_axis_write_desc_status_error,
               m_axis_write_desc_status_valid,
        output s_axis_write_data_tdata, s_axis_write_data_tkeep, s_axis_write_data_tvalid,
               s_axis_write_data_tlast, s_axis_write_data_tid, s_axis_write_data_tdest,
               s_axis_write_data_tuser,
        input  s_axis_write_data_tready,
        input  ram_wr_cmd_be, ram_wr_cmd_addr, ram_wr_cmd_data, ram_wr_cmd_valid,
        output ram_wr_cmd_ready, ram_wr_done
    );
endinterface
`default_nettype wire

// File: rtl/dma_client_axis_sink_seg.sv
`default_nettype none
// ============================================================================
//  Module   : dma_client_axis_sink_seg
//  Brief    : One RAM segment: write command register plus outstanding counter.
//  Revision : 1.0 - initial release
// ============================================================================
module dma_client_axis_sink_seg #(
    parameter int SEG_DATA_WIDTH  = 64,
    parameter int SEG_ADDR_WIDTH  = 8,
    parameter int SEG_BE_WIDTH    = SEG_DATA_WIDTH/8,
    parameter int MAX_OUTSTANDING = 16
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      i_load,
    input  wire logic [SEG_BE_WIDTH-1:0]   i_be,
    input  wire logic [SEG_ADDR_WIDTH-1:0] i_addr,
    input  wire logic [SEG_DATA_WIDTH-1:0] i_data,
    input  wire logic                      i_cmd_ready,
    input  wire logic                      i_wr_done,
    output logic      [SEG_BE_WIDTH-1:0]   o_cmd_be,
    output logic      [SEG_ADDR_WIDTH-1:0] o_cmd_addr,
    output logic      [SEG_DATA_WIDTH-1:0] o_cmd_data,
    output logic                           o_cmd_valid,
    output logic                           o_free,
    output logic                           o_full,
    output logic                           o_idle
);
    // One extra count: a held command may still issue after the limit is hit.
    localparam int c_cnt_w = $clog2(MAX_OUTSTANDING + 2);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_issue;

    assign w_issue = o_cmd_valid & i_cmd_ready;
    assign o_free  = !o_cmd_valid || i_cmd_ready;
    assign o_full  = r_cnt >= c_cnt_w'(MAX_OUTSTANDING);
    assign o_idle  = !o_cmd_valid && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cmd_valid <= 1'b0;
            o_cmd_be    <= '0;
            o_cmd_addr  <= '0;
            o_cmd_data  <= '0;
            r_cnt       <= '0;
        end else begin
            if (i_load) begin
                o_cmd_valid <= 1'b1;
                o_cmd_be    <= i_be;
                o_cmd_addr  <= i_addr;
                o_cmd_data  <= i_data;
            end else if (i_cmd_ready) begin
                o_cmd_valid <= 1'b0;
            end

            case ({w_issue, i_wr_done})
                2'b10:   r_cnt <= r_cnt + c_cnt_w'(1);
                2'b01:   if (r_cnt != '0) r_cnt <= r_cnt - c_cnt_w'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/dma_client_axis_sink.sv
`default_nettype none
// ============================================================================
//  Module   : dma_client_axis_sink
//  Brief    : Writes one AXI stream frame per descriptor into segmented RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module dma_client_axis_sink #(
    parameter int SEG_COUNT       = 2,
    parameter int SEG_DATA_WIDTH  = 64,
    parameter int SEG_ADDR_WIDTH  = 8,
    parameter int SEG_BE_WIDTH    = SEG_DATA_WIDTH/8,
    parameter int RAM_ADDR_WIDTH  = SEG_ADDR_WIDTH+$clog2(SEG_COUNT)+$clog2(SEG_BE_WIDTH),
    parameter int AXIS_DATA_WIDTH = SEG_COUNT*SEG_DATA_WIDTH,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
    parameter int AXIS_ID_WIDTH   = 8,
    parameter int AXIS_DEST_WIDTH = 8,
    parameter int AXIS_USER_WIDTH = 1,
    parameter int LEN_WIDTH       = 20,
    parameter int TAG_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              enable,
    dma_client_axis_sink_if.slave  bus
);
    import dma_client_axis_sink_pkg::*;

    localparam int unsigned c_addr_shift = seg_addr_shift(AXIS_KEEP_WIDTH);

    state_t                         r_state, w_state_next;
    logic [SEG_ADDR_WIDTH-1:0]      r_addr;
    logic [LEN_WIDTH-1:0]           r_len, r_byte_cnt;
    logic [TAG_WIDTH-1:0]           r_tag;
    logic                           r_error;
    logic [AXIS_ID_WIDTH-1:0]       r_id;
    logic [AXIS_DEST_WIDTH-1:0]     r_dest;
    logic [AXIS_USER_WIDTH-1:0]     r_user;
    logic                           r_status_valid;

    logic                           w_desc_ready, w_tready;
    logic                           w_desc_accept, w_beat_accept, w_status_fire;
    logic [AXIS_KEEP_WIDTH-1:0]     w_be;
    logic                           w_overrun;
    logic [LEN_WIDTH:0]             w_off, w_beat_bytes, w_cnt_sum;
    logic [SEG_COUNT-1:0]           w_seg_load, w_seg_free, w_seg_full, w_seg_idle;
    logic                           w_all_free, w_any_full, w_all_idle;

    assign w_all_free = &w_seg_free;
    assign w_any_full = |w_seg_full;
    assign w_all_idle = &w_seg_idle;

    always_comb begin
        w_state_next = r_state;
        w_desc_ready = 1'b0;
        w_tready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_desc_ready = enable;
                if (enable && bus.s_axis_write_desc_valid) w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                w_tready = w_all_free && !w_any_full;
                if (w_tready && bus.s_axis_write_data_tvalid && bus.s_axis_write_data_tlast)
                    w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_all_idle) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_desc_accept = w_desc_ready && bus.s_axis_write_desc_valid;
    assign w_beat_accept = w_tready && bus.s_axis_write_data_tvalid;
    assign w_status_fire = (r_state == ST_DRAIN) && w_all_idle;

    // Bytes landing at or past the descriptor length are dropped and flagged.
    always_comb begin
        w_be      = '0;
        w_overrun = 1'b0;
        w_off     = '0;
        for (int j = 0; j < AXIS_KEEP_WIDTH; j++) begin
            w_off = {1'b0, r_byte_cnt} + (LEN_WIDTH+1)'(j);
            if (bus.s_axis_write_data_tkeep[j]) begin
                if (w_off < {1'b0, r_len}) w_be[j] = 1'b1;
                else                       w_overrun = 1'b1;
            end
        end
    end

    assign w_beat_bytes = (LEN_WIDTH+1)'(popcount(c_max_keep_width'(bus.s_axis_write_data_tkeep)));
    assign w_cnt_sum    = {1'b0, r_byte_cnt} + w_beat_bytes;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr         <= '0;
            r_len          <= '0;
            r_byte_cnt     <= '0;
            r_tag          <= '0;
            r_error        <= 1'b0;
            r_id           <= '0;
            r_dest         <= '0;
            r_user         <= '0;
            r_status_valid <= 1'b0;
        end else begin
            r_status_valid <= w_status_fire;
            if (w_desc_accept) begin
                r_addr     <= SEG_ADDR_WIDTH'(bus.s_axis_write_desc_ram_addr >> c_addr_shift);
                r_len      <= bus.s_axis_write_desc_len;
                r_tag      <= bus.s_axis_write_desc_tag;
                r_byte_cnt <= '0;
                r_error    <= 1'b0;
            end
            if (w_beat_accept) begin
                r_addr     <= r_addr + SEG_ADDR_WIDTH'(1);
                r_byte_cnt <= w_cnt_sum[LEN_WIDTH] ? '1 : w_cnt_sum[LEN_WIDTH-1:0];
                if (w_overrun) r_error <= 1'b1;
                if (bus.s_axis_write_data_tlast) begin
                    r_id   <= bus.s_axis_write_data_tid;
                    r_dest <= bus.s_axis_write_data_tdest;
                    r_user <= bus.s_axis_write_data_tuser;
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < SEG_COUNT; i++) begin : g_seg
            assign w_seg_load[i] = w_beat_accept && (|w_be[i*SEG_BE_WIDTH +: SEG_BE_WIDTH]);

            dma_client_axis_sink_seg #(
                .SEG_DATA_WIDTH  (SEG_DATA_WIDTH),
                .SEG_ADDR_WIDTH  (SEG_ADDR_WIDTH),
                .SEG_BE_WIDTH    (SEG_BE_WIDTH),
                .MAX_OUTSTANDING (MAX_OUTSTANDING)
            ) u_seg (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_load      (w_seg_load[i]),
                .i_be        (w_be[i*SEG_BE_WIDTH +: SEG_BE_WIDTH]),
                .i_addr      (r_addr),
                .i_data      (bus.s_axis_write_data_tdata[i*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
                .i_cmd_ready (bus.ram_wr_cmd_ready[i]),
                .i_wr_done   (bus.ram_wr_done[i]),
                .o_cmd_be    (bus.ram_wr_cmd_be[i*SEG_BE_WIDTH +: SEG_BE_WIDTH]),
                .o_cmd_addr  (bus.ram_wr_cmd_addr[i*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH]),
                .o_cmd_data  (bus.ram_wr_cmd_data[i*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
                .o_cmd_valid (bus.ram_wr_cmd_valid[i]),
                .o_free      (w_seg_free[i]),
                .o_full      (w_seg_full[i]),
                .o_idle      (w_seg_idle[i])
            );
        end
    endgenerate

    assign bus.s_axis_write_desc_ready        = w_desc_ready;
    assign bus.s_axis_write_data_tready       = w_tready;
    assign bus.m_axis_write_desc_status_valid = r_status_valid;
    assign bus.m_axis_write_desc_status_len   = r_byte_cnt;
    assign bus.m_axis_write_desc_status_tag   = r_tag;
    assign bus.m_axis_write_desc_status_error = r_error;
    assign bus.m_axis_write_desc_status_id    = r_id;
    assign bus.m_axis_write_desc_status_dest  = r_dest;
    assign bus.m_axis_write_desc_status_user  = r_user;
endmodule
`default_nettype wire
